uart_rx_fifo_cfg: RTL and testbench
===================================

// Module: uart_rx_fifo_cfg
// PURPOSE
//   Parametrised UART receiver: 2-flop rxd sync, 3-sample majority vote, runtime parity/stop config.
//   Buffers received words in an internal FIFO and presents them on an AXI-Stream master.
//   Flags frame, parity, overrun and break. Next-generation drop-in for the 8N1 uart_rx in the UART subsystem.
// PARAMETERS
//   DATA_WIDTH  8   data bits per frame (5..9), LSB first on the line
//   FIFO_DEPTH  4   RX FIFO entries; power of two, >=2
// PORTS
//   clk            in   1             system clock
//   rst_n          in   1             asynchronous active-low reset
//   rxd            in   1             serial input, idle high, asynchronous to clk
//   prescale       in   16            bit period P = prescale*8 clk; 0 treated as 1
//   parity_mode    in   2             00/11 none, 01 even, 10 odd
//   stop_bits2     in   1             0: one stop bit, 1: two stop bits
//   m_axis_tdata   out  DATA_WIDTH    head-of-FIFO word
//   m_axis_tuser   out  1             head word had parity error
//   m_axis_tvalid  out  1             FIFO not empty
//   m_axis_tready  in   1             consumer accepts head word
//   fifo_level     out  $clog2(D)+1   words in FIFO
//   busy           out  1             FSM not IDLE
//   overrun_error  out  1             1-clk pulse: word dropped, FIFO full
//   frame_error    out  1             1-clk pulse: stop bit sampled low
//   parity_error   out  1             1-clk pulse: parity mismatch
//   break_detect   out  1             1-clk pulse: all-zero frame with low stop
// BEHAVIOUR
//   Reset: FSM IDLE, sync flops=1, FIFO empty, all outputs 0 (tdata 0). Reset mid-frame aborts the frame; no push.
//   Sync: rxd passes 2 flops (2-clk latency); all logic uses synced rxd_s.
//   Config latch: prescale, parity_mode and stop_bits2 are latched on start-edge detection. Changes mid-frame take effect next frame.
//   Sampling: 19-bit cycle counter. Bit value = majority of rxd_s at counts mid-1, mid, mid+1 of each bit.
//   FSM:
//     IDLE  -> START on rxd_s falling edge.
//     START: vote at P/2. If 1: false start, -> IDLE, no flags. Else -> DATA.
//     DATA: DATA_WIDTH votes spaced P, shifted in LSB-first.
//       -> PARITY if parity enabled, else -> STOP.
//     PARITY: one vote. Even: XOR(data,p) must be 0. Odd: must be 1.
//     STOP: one vote (two if stop_bits2). Any stop low -> frame_error.
//       If frame error and data=0 and parity bit=0: break_detect too, -> BREAK. Else -> IDLE.
//     BREAK: wait for rxd_s=1, -> IDLE.
//   Push: on the final stop vote, if no frame error. Word+parity flag pushed; tvalid rises next clk (1-clk latency).
//   Frame-errored and break frames are discarded. Parity-errored words are kept with tuser=1.
//   Full: push when full and no pop that cycle -> word dropped, overrun_error pulses.
//     Push+pop same cycle while full -> push accepted, level unchanged.
//   FIFO is first-word-fall-through. Pop = tvalid&tready. Pointers wrap modulo FIFO_DEPTH. Pop on empty is ignored.
//   Error pulses assert in the cycle of the deciding vote. parity_error and frame_error may pulse together.
//   busy=1 from the start edge until return to IDLE (includes BREAK).
// STRUCTURE
//   uart_pkg: rx_state_e enum (IDLE,START,DATA,PARITY,STOP,BREAK), parity_e enum, PARITY_* constants.
//   Sub-module uart_rx_fifo: DATA_WIDTH+1 wide FWFT FIFO with level, full, empty.
//     Instantiated once; FSM and sampler stay in the top.
// TESTING  (clk 100 MHz, prescale=4 -> P=32 clk)
//   8N1, send 0xA5 then 0x3C, tready=1
//     -> two beats 0xA5, 0x3C, tuser=0, no error pulses.
//   parity even, send 0x07 with parity bit 0 (wrong)
//     -> beat 0x07, tuser=1, one parity_error pulse.
//   stop_bits2=1, second stop driven low
//     -> frame_error pulse, no beat, fifo_level stays 0.
//   rxd low for 12*P, then high
//     -> frame_error + break_detect once; busy=1 until rxd high; no beat.
//   tready=0, send 5 bytes 0x01..0x05, FIFO_DEPTH=4
//     -> fifo_level=4, overrun_error on 5th.
//     Then tready=1 -> drains 0x01..0x04 in order.
//   rxd low glitch 8 clk; separately rst_n low mid-DATA
//     -> glitch: no start, busy returns 0.
//     -> reset: all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  // Raw parity_mode port encodings (2'b11 also means no parity).
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  // Bit-period counter width: 65535*8 fits in 19 bits.
  localparam int CNT_W = 19;

  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      PARITY_EVEN: decode_parity = PAR_EVEN;
      PARITY_ODD:  decode_parity = PAR_ODD;
      PARITY_NONE: decode_parity = PAR_NONE;
      default:     decode_parity = PAR_NONE;
    endcase
  endfunction

  // Bit period in clk cycles; prescale of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] bit_period(input logic [15:0] prescale);
    logic [15:0] ps;
    ps = (prescale == 16'd0) ? 16'd1 : prescale;
    bit_period = {ps, 3'b000};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received words plus their parity flag.
module uart_rx_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A push into a full FIFO is accepted only if the head leaves the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers (wrap naturally at power-of-two depth) and level.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_cfg.sv
// UART receiver with runtime parity/stop configuration, majority-vote sampling,
// error/break flags and a buffered AXI-Stream output.
// Stream handshake: a beat transfers on a clock edge where m_axis_tvalid and
// m_axis_tready are both high; tvalid stays high while the FIFO is not empty and
// tdata/tuser hold the head word until it transfers.
module uart_rx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic [15:0]                   prescale,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits2,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overrun_error,
  output logic                          frame_error,
  output logic                          parity_error,
  output logic                          break_detect
);

  localparam int BW = $clog2(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic                  rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            vote_q, vote_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  stop_n_q, stop_n_d;
  logic [CNT_W-1:0]      p_q, p_d;
  parity_e               pmode_q, pmode_d;
  logic                  stop2_q, stop2_d;

  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  at_decide;
  logic                  vote;
  logic                  fall_edge;
  logic                  par_calc;
  logic [CNT_W-1:0]      p_new;

  // Counter is timed relative to the previous vote: the next vote lands P cycles
  // later at count P-1, with the two earlier samples at P-3 and P-2.
  assign at_decide = (cnt_q == p_q - 19'd1);
  assign vote      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s_q) | (vote_q[1] & rxd_s_q);
  assign fall_edge = rxd_prev_q & ~rxd_s_q;
  assign par_calc  = ^shreg_q ^ vote;
  assign p_new     = bit_period(prescale);

  // Receive FSM: next state, sampling, shift register and error pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    vote_d        = vote_q;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    par_bit_d     = par_bit_q;
    par_err_d     = par_err_q;
    stop_err_d    = stop_err_q;
    stop_n_d      = stop_n_q;
    p_d           = p_q;
    pmode_d       = pmode_q;
    stop2_d       = stop2_q;
    push          = 1'b0;
    frame_error   = 1'b0;
    parity_error  = 1'b0;
    break_detect  = 1'b0;

    if (state_q inside {START, DATA, PARITY, STOP}) begin
      cnt_d = at_decide ? '0 : cnt_q + 19'd1;
      if (cnt_q == p_q - 19'd3) vote_d[0] = rxd_s_q;
      if (cnt_q == p_q - 19'd2) vote_d[1] = rxd_s_q;
    end

    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          // Latch the frame configuration; the start vote lands P/2+1 cycles on.
          p_d        = p_new;
          pmode_d    = decode_parity(parity_mode);
          stop2_d    = stop_bits2;
          cnt_d      = p_new - 19'd2 - (p_new >> 1);
          bit_d      = '0;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
          stop_n_d   = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (at_decide) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (at_decide) begin
          shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = (pmode_q == PAR_NONE) ? STOP : PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_decide) begin
          par_bit_d    = vote;
          parity_error = (pmode_q == PAR_EVEN) ? par_calc : ~par_calc;
          par_err_d    = parity_error;
          state_d      = STOP;
        end
      end
      STOP: begin
        if (at_decide) begin
          if (stop2_q && !stop_n_q) begin
            stop_err_d = ~vote;
            stop_n_d   = 1'b1;
          end else if (stop_err_q || !vote) begin
            frame_error = 1'b1;
            if (shreg_q == '0 && !par_bit_q) begin
              break_detect = 1'b1;
              state_d      = BREAK;
            end else begin
              state_d = IDLE;
            end
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        if (rxd_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchroniser, FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      cnt_q      <= '0;
      vote_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      stop_n_q   <= 1'b0;
      p_q        <= 19'd8;
      pmode_q    <= PAR_NONE;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
      cnt_q      <= cnt_d;
      vote_q     <= vote_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      stop_n_q   <= stop_n_d;
      p_q        <= p_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
    end
  end

  assign pop           = m_axis_tvalid & m_axis_tready;
  assign overrun_error = push & fifo_full & ~pop;
  assign busy          = (state_q != IDLE);
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_head[DATA_WIDTH-1:0];
  assign m_axis_tuser  = fifo_head[DATA_WIDTH];

  uart_rx_fifo #(
    .W     (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({par_err_q, shreg_q}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_fifo_cfg.sv
// Self-checking bench for uart_rx_fifo_cfg (8 data bits, 4-entry FIFO, P=32 clk).
module tb_uart_rx_fifo_cfg;

  localparam int P = 32;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic [15:0] prescale;
  logic [1:0]  parity_mode;
  logic        stop_bits2;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [2:0]  fifo_level;
  logic        busy;
  logic        overrun_error;
  logic        frame_error;
  logic        parity_error;
  logic        break_detect;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_beats = 0;
  int n_fe = 0;
  int n_pe = 0;
  int n_ovr = 0;
  int n_brk = 0;

  logic [8:0] exp_q[$];

  uart_rx_fifo_cfg #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .prescale      (prescale),
    .parity_mode   (parity_mode),
    .stop_bits2    (stop_bits2),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .break_detect  (break_detect)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: compare each accepted beat with the oldest expected word
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      n_beats++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got tuser=%0b tdata=0x%02h, required no beat",
                 m_axis_tuser, m_axis_tdata);
      end else begin
        logic [8:0] exp;
        exp = exp_q.pop_front();
        if ({m_axis_tuser, m_axis_tdata} !== exp) begin
          n_fail++;
          $display("FAIL beat: got tuser=%0b tdata=0x%02h, required tuser=%0b tdata=0x%02h",
                   m_axis_tuser, m_axis_tdata, exp[8], exp[7:0]);
        end
      end
    end
  end

  // Pulse counters for error flags
  always @(negedge clk) begin
    if (frame_error)   n_fe++;
    if (parity_error)  n_pe++;
    if (overrun_error) n_ovr++;
    if (break_detect)  n_brk++;
  end

  // Driver tasks
  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (P) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic two_stop, input logic stop2_val);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(1'b1);
    if (two_stop) drive_bit(stop2_val);
    drive_bit(1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 8 * P; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %0b required 0", m_axis_tvalid); end
    n_cmp++;
    if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_tdata: got 0x%02h required 0x00", m_axis_tdata); end
    n_cmp++;
    if (m_axis_tuser !== 1'b0) begin n_fail++; $display("FAIL rst_tuser: got %0b required 0", m_axis_tuser); end
    n_cmp++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
    n_cmp++;
    if ({overrun_error, frame_error, parity_error, break_detect} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_flags: got %04b required 0000",
               {overrun_error, frame_error, parity_error, break_detect});
    end
    n_cmp++;
  endtask

  task automatic test_8n1();
    int fe0, pe0;
    fe0 = n_fe; pe0 = n_pe;
    parity_mode = 2'b00; stop_bits2 = 1'b0; m_axis_tready = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("8n1");
    check_int("8n1_frame_err", n_fe - fe0, 0);
    check_int("8n1_parity_err", n_pe - pe0, 0);
  endtask

  task automatic test_parity();
    int pe0, fe0;
    pe0 = n_pe; fe0 = n_fe;
    parity_mode = 2'b01; stop_bits2 = 1'b0; m_axis_tready = 1'b1;
    // 0x07 has three ones, so correct even parity would be 1; send 0.
    exp_q.push_back({1'b1, 8'h07});
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("parity");
    check_int("parity_err_pulses", n_pe - pe0, 1);
    check_int("parity_frame_err", n_fe - fe0, 0);
    // Odd parity with correct bit: 0x07 -> parity bit 0, no error.
    parity_mode = 2'b10;
    exp_q.push_back({1'b0, 8'h07});
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("parity_odd");
    check_int("parity_odd_pulses", n_pe - pe0, 1);
  endtask

  task automatic test_stop2();
    int fe0, b0;
    fe0 = n_fe; b0 = n_beats;
    parity_mode = 2'b00; stop_bits2 = 1'b1; m_axis_tready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (P) @(negedge clk);
    check_int("stop2_frame_err", n_fe - fe0, 1);
    check_int("stop2_beats", n_beats - b0, 0);
    check_int("stop2_level", int'(fifo_level), 0);
    stop_bits2 = 1'b0;
  endtask

  task automatic test_break();
    int fe0, brk0, b0;
    fe0 = n_fe; brk0 = n_brk; b0 = n_beats;
    parity_mode = 2'b00; stop_bits2 = 1'b0;
    @(negedge clk);
    rxd = 1'b0;
    repeat (11 * P) @(negedge clk);
    check_int("break_busy_low_line", int'(busy), 1);
    repeat (P) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check_int("break_busy_released", int'(busy), 0);
    check_int("break_frame_err", n_fe - fe0, 1);
    check_int("break_pulses", n_brk - brk0, 1);
    check_int("break_beats", n_beats - b0, 0);
    repeat (P) @(negedge clk);
  endtask

  task automatic test_overrun();
    int ovr0;
    ovr0 = n_ovr;
    parity_mode = 2'b00; m_axis_tready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({1'b0, 8'(i)});
      send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_int("overrun_level", int'(fifo_level), 4);
    check_int("overrun_pulses", n_ovr - ovr0, 1);
    check_int("overrun_tvalid", int'(m_axis_tvalid), 1);
    @(negedge clk);
    m_axis_tready = 1'b1;
    wait_drain("overrun");
    @(negedge clk);
    check_int("overrun_level_after", int'(fifo_level), 0);
  endtask

  task automatic test_glitch();
    int b0;
    b0 = n_beats;
    @(negedge clk);
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    check_int("glitch_busy_seen", int'(busy), 1);
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (P) @(negedge clk);
    check_int("glitch_busy_idle", int'(busy), 0);
    check_int("glitch_beats", n_beats - b0, 0);
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b0;
    parity_mode = 2'b00;
    // Leave a word in the FIFO so the reset flush is visible.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_int("rstmid_busy", int'(busy), 0);
    check_int("rstmid_tvalid", int'(m_axis_tvalid), 0);
    check_int("rstmid_level", int'(fifo_level), 0);
    check_int("rstmid_tdata", int'(m_axis_tdata), 0);
    rxd = 1'b1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_axis_tready = 1'b1;
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("rstmid");
  endtask

  initial begin
    rst_n = 1'b0;
    rxd = 1'b1;
    prescale = 16'd4;
    parity_mode = 2'b00;
    stop_bits2 = 1'b0;
    m_axis_tready = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_8n1();
    test_parity();
    test_stop2();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
